// File: rtl/capture_buffer.sv
// Triggered 256-sample acquisition buffer that publishes to the display array on a vblank rising edge.
// Optional forced trigger after a timeout in ARMED is enabled by defining AUTO_TRIG_EN.
module capture_buffer #(
  parameter int DECIM        = 1,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic [7:0] trig_level,
  input  logic       trig_slope,
  input  logic       vblnk,
  output logic [7:0] data_display [0:255],
  output logic       frame_updated,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    READY   = 2'b11
  } state_t;

  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  state_t     st;
  logic [7:0] cap_mem [0:255];
  logic [7:0] idx;
  logic [7:0] decim_cnt;
  logic [7:0] prev;
  logic       prev_valid;
  logic       vblnk_q;

  logic rise_trig;
  logic fall_trig;
  logic level_trig;
  logic force_trig;
  logic trigger;
  logic decim_hit;
  logic vblnk_edge;

  assign state = st;

  // Stream semantics: sample_in is consumed only in cycles where sample_valid is high;
  // there is no backpressure, so every valid sample is either used or dropped.
  assign rise_trig  = prev_valid && (prev <  trig_level) && (sample_in >= trig_level);
  assign fall_trig  = prev_valid && (prev >= trig_level) && (sample_in <  trig_level);
  assign level_trig = trig_slope ? fall_trig : rise_trig;
  assign trigger    = sample_valid && (level_trig || force_trig);
  assign decim_hit  = (decim_cnt == DECIM_LAST);
  assign vblnk_edge = vblnk && !vblnk_q;

`ifdef AUTO_TRIG_EN
  logic [31:0] timeout_cnt;

  // Held at zero outside ARMED so every arming starts a fresh timeout; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (st != ARMED) begin
      timeout_cnt <= '0;
    end else if (timeout_cnt != 32'(AUTO_TIMEOUT)) begin
      timeout_cnt <= timeout_cnt + 32'd1;
    end
  end

  assign force_trig = (timeout_cnt == 32'(AUTO_TIMEOUT));
`else
  assign force_trig = 1'b0;
`endif

  // Capture storage carries no reset; its contents are only visible after a full capture.
  always_ff @(posedge clk) begin
    if (st == ARMED && trigger) begin
      cap_mem[0] <= sample_in;
    end else if (st == CAPTURE && sample_valid && decim_hit) begin
      cap_mem[idx] <= sample_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st            <= IDLE;
      frame_updated <= 1'b0;
      idx           <= '0;
      decim_cnt     <= '0;
      prev          <= '0;
      prev_valid    <= 1'b0;
      vblnk_q       <= 1'b0;
      for (int i = 0; i < 256; i++) begin
        data_display[i] <= '0;
      end
    end else begin
      frame_updated <= 1'b0;
      vblnk_q       <= vblnk;
      case (st)
        IDLE: begin
          prev_valid <= 1'b0;
          st         <= ARMED;
        end
        ARMED: begin
          if (sample_valid) begin
            prev       <= sample_in;
            prev_valid <= 1'b1;
          end
          if (trigger) begin
            idx       <= 8'd1;
            decim_cnt <= '0;
            st        <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            if (decim_hit) begin
              decim_cnt <= '0;
              // idx stops at 255; the store there completes the capture.
              if (idx == 8'hFF) begin
                st <= READY;
              end else begin
                idx <= idx + 8'd1;
              end
            end else begin
              decim_cnt <= decim_cnt + 8'd1;
            end
          end
        end
        READY: begin
          if (vblnk_edge) begin
            for (int i = 0; i < 256; i++) begin
              data_display[i] <= cap_mem[i];
            end
            frame_updated <= 1'b1;
            st            <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: trigger vector table plus capture/publish sequences.
module tb_capture_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic       vblnk;

  logic [7:0] sample_in1, sample_in4, sample_ina;
  logic       sample_valid1, sample_valid4, sample_valida;

  logic [7:0] dd1 [0:255];
  logic [7:0] dd4 [0:255];
  logic [7:0] dda [0:255];
  logic       fu1, fu4, fua;
  logic [1:0] st1, st4, sta;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  capture_buffer #(.DECIM(1), .AUTO_TIMEOUT(1000000)) dut1 (
    .clk(clk), .rst(rst), .sample_in(sample_in1), .sample_valid(sample_valid1),
    .trig_level(trig_level), .trig_slope(trig_slope), .vblnk(vblnk),
    .data_display(dd1), .frame_updated(fu1), .state(st1));

  capture_buffer #(.DECIM(4), .AUTO_TIMEOUT(1000000)) dut4 (
    .clk(clk), .rst(rst), .sample_in(sample_in4), .sample_valid(sample_valid4),
    .trig_level(trig_level), .trig_slope(trig_slope), .vblnk(vblnk),
    .data_display(dd4), .frame_updated(fu4), .state(st4));

  capture_buffer #(.DECIM(1), .AUTO_TIMEOUT(100)) duta (
    .clk(clk), .rst(rst), .sample_in(sample_ina), .sample_valid(sample_valida),
    .trig_level(trig_level), .trig_slope(trig_slope), .vblnk(vblnk),
    .data_display(dda), .frame_updated(fua), .state(sta));

  typedef struct {
    logic [7:0] prev;
    logic [7:0] cur;
    logic [7:0] level;
    logic       slope;
    logic [1:0] exp_state;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] s);
    sample_in1 = s;
    sample_valid1 = 1'b1;
    tick();
    sample_valid1 = 1'b0;
  endtask

  task automatic send4(input logic [7:0] s);
    sample_in4 = s;
    sample_valid4 = 1'b1;
    tick();
    sample_valid4 = 1'b0;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic logic get_fu(input int w);
    case (w)
      1:       return fu1;
      4:       return fu4;
      default: return fua;
    endcase
  endfunction

  function automatic logic [7:0] get_dd(input int w, input int i);
    case (w)
      1:       return dd1[i];
      4:       return dd4[i];
      default: return dda[i];
    endcase
  endfunction

  // Waits for the publish pulse, then pops and compares the full expected trace.
  task automatic wait_frame(input int w, input int budget);
    int  n = 0;
    bit  seen = 1'b0;
    logic [7:0] e;
    while (!seen && n < budget) begin
      if (get_fu(w)) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check($sformatf("frame_seen_dut%0d", w), 32'(seen), 32'd1);
    if (seen) begin
      for (int i = 0; i < 256; i++) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd0, 32'd1);
          break;
        end
        e = exp_q.pop_front();
        check($sformatf("dd%0d[%0d]", w, i), 32'(get_dd(w, i)), 32'(e));
      end
      tick();
      check($sformatf("frame_pulse_width_dut%0d", w), 32'(get_fu(w)), 32'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt [8];
    logic [7:0] r;
    bit all_zero;
    int n;

    rst = 1'b1;
    trig_level = 8'h80;
    trig_slope = 1'b0;
    vblnk = 1'b0;
    sample_in1 = '0; sample_in4 = '0; sample_ina = '0;
    sample_valid1 = 1'b0; sample_valid4 = 1'b0; sample_valida = 1'b0;

    vt[0] = '{8'h7F, 8'h80, 8'h80, 1'b0, 2'b10};
    vt[1] = '{8'h80, 8'h90, 8'h80, 1'b0, 2'b01};
    vt[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 2'b01};
    vt[3] = '{8'hFF, 8'h00, 8'h00, 1'b1, 2'b01};
    vt[4] = '{8'h80, 8'h7F, 8'h80, 1'b1, 2'b10};
    vt[5] = '{8'h40, 8'h40, 8'h40, 1'b1, 2'b01};
    vt[6] = '{8'h00, 8'hFF, 8'hFF, 1'b0, 2'b10};
    vt[7] = '{8'h10, 8'h90, 8'h80, 1'b1, 2'b01};

    // Reset state
    #12;
    check("reset_state", 32'(st1), 32'd0);
    check("reset_frame_updated", 32'(fu1), 32'd0);
    check("reset_dd0", 32'(dd1[0]), 32'd0);
    check("reset_dd255", 32'(dd1[255]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("armed_after_reset", 32'(st1), 32'd1);

    // Ramp, rising at 0x80, DECIM=1
    for (int i = 0; i < 256; i++) exp_q.push_back(8'((8'h80 + i) & 8'hFF));
    for (int i = 0; i < 384; i++) begin
      send1(8'(i));
      if (i == 200) check("ramp_in_capture", 32'(st1), 32'd2);
    end
    check("ramp_ready", 32'(st1), 32'd3);
    vblnk = 1'b1;
    wait_frame(1, 10);
    vblnk = 1'b0;
    check("rearm_after_frame", 32'(st1), 32'd1);

    // Falling at 0x40 with vblnk toggling through ARMED/CAPTURE; last store coincides with an edge
    trig_level = 8'h40;
    trig_slope = 1'b1;
    vblnk = 1'b1;
    send1(8'h50);
    vblnk = 1'b0;
    send1(8'h30);
    check("falling_trigger", 32'(st1), 32'd2);
    exp_q.push_back(8'h30);
    for (int k = 1; k < 256; k++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back(r);
      vblnk = k[0];
      send1(r);
      check("no_update_in_capture", 32'(fu1), 32'd0);
    end
    check("ready_after_capture", 32'(st1), 32'd3);
    check("held_trace_dd0", 32'(dd1[0]), 32'h80);
    check("held_trace_dd255", 32'(dd1[255]), 32'h7F);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("coincident_edge_ignored", 32'(fu1), 32'd0);
    end
    vblnk = 1'b0;
    tick();
    vblnk = 1'b1;
    wait_frame(1, 5);
    vblnk = 1'b0;

    // Reset mid-capture with a trace loaded
    check("pre_reset_dd0", 32'(dd1[0]), 32'h30);
    send1(8'h50);
    send1(8'h30);
    send1(8'h11);
    check("mid_capture", 32'(st1), 32'd2);
    #3;
    rst = 1'b1;
    #1;
    all_zero = 1'b1;
    for (int i = 0; i < 256; i++) if (dd1[i] !== 8'h00) all_zero = 1'b0;
    check("async_reset_dd_clear", 32'(all_zero), 32'd1);
    check("async_reset_state", 32'(st1), 32'd0);
    check("async_reset_fu", 32'(fu1), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Trigger condition table
    for (int v = 0; v < 8; v++) begin
      reset_dut();
      trig_level = vt[v].level;
      trig_slope = vt[v].slope;
      send1(vt[v].prev);
      send1(vt[v].cur);
      check($sformatf("trig_vec%0d", v), 32'(st1), 32'(vt[v].exp_state));
    end

    // DECIM=4 ramp with valid gaps
    reset_dut();
    trig_level = 8'h10;
    trig_slope = 1'b0;
    for (int k = 0; k < 256; k++) exp_q.push_back(8'((8'h10 + 4 * k) & 8'hFF));
    n = 0;
    while (st4 != 2'b11 && n < 2000) begin
      send4(8'(n));
      if ($urandom_range(0, 3) == 0) tick();
      n++;
    end
    check("decim4_ready", 32'(st4), 32'd3);
    check("decim4_sample_count", 32'(n), 32'd1037);
    vblnk = 1'b1;
    wait_frame(4, 5);
    vblnk = 1'b0;

    // Constant input below level: auto trigger only when enabled
    reset_dut();
    trig_level = 8'h80;
    trig_slope = 1'b0;
    sample_ina = 8'h20;
    sample_valida = 1'b1;
    repeat (50) tick();
    check("auto_early_armed", 32'(sta), 32'd1);
    repeat (100) tick();
`ifdef AUTO_TRIG_EN
    check("auto_forced_capture", 32'(sta), 32'd2);
    for (int k = 0; k < 256; k++) exp_q.push_back(8'h20);
    n = 0;
    while (sta != 2'b11 && n < 400) begin
      tick();
      n++;
    end
    check("auto_ready", 32'(sta), 32'd3);
    sample_valida = 1'b0;
    vblnk = 1'b1;
    wait_frame(2, 5);
    vblnk = 1'b0;
`else
    check("no_auto_stays_armed", 32'(sta), 32'd1);
    sample_valida = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
